seq_control_unit: RTL and testbench
===================================

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 4..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: request a new operation.
REQ-005 SHALL have port ctrl, input, 2 bits: opcode (00 A+B, 01 A-B, 10 A*B signed, 11 A&B).
REQ-006 SHALL have port a, input, WIDTH bits: operand A, two's complement.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, two's complement.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when results update.
REQ-010 SHALL have port res_l, output, WIDTH bits: low result word.
REQ-011 SHALL have port res_h, output, WIDTH bits: high result word.
REQ-012 SHALL have ports zero, overflow and cout, each output, 1 bit: result flags.

Function
REQ-013 SHALL implement three states: IDLE, MUL, DONE.
REQ-014 In IDLE, start=1 SHALL latch a, b and ctrl; ctrl=10 goes to MUL, all other opcodes go to DONE.
REQ-015 start SHALL be ignored in MUL and DONE; latched operands SHALL NOT change until the next accepted start.
REQ-016 Add/sub/and SHALL compute from latched operands and register results on the IDLE->DONE edge; done is high the cycle after acceptance (latency 1).
REQ-017 MUL SHALL perform an iterative signed multiply using a cycle counter, running exactly WIDTH cycles, then go to DONE; done is high WIDTH+1 cycles after acceptance.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE; a start in that cycle SHALL be ignored.
REQ-019 Sub SHALL compute a + ~b + 1; cout is the carry out of the MSB (1 = no borrow).
REQ-020 Add/sub overflow SHALL be set when operand signs imply a result sign mismatch (signed overflow).
REQ-021 For add/sub, res_h SHALL equal WIDTH copies of cout.
REQ-022 For and, res_l SHALL be a&b; res_h, cout and overflow SHALL be 0.
REQ-023 For mul, {res_h,res_l} SHALL be the 2*WIDTH-bit signed product.
REQ-024 For mul, cout SHALL be 0, and overflow SHALL be 1 when the product does not fit in WIDTH signed bits.
REQ-025 zero SHALL be 1 when res_l==0 for add/sub/and, or when {res_h,res_l}==0 for mul.
REQ-026 Result and flag outputs SHALL hold their values from the last completed operation until the next done.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, res_l=0, res_h=0, zero=0, overflow=0, cout=0, and clear the counter and latched operands.
REQ-028 Reset SHALL override start and any in-flight operation, including mid-MUL; no done is produced for an aborted operation.

Configuration
REQ-029 Macro SEQ_CU_SAT_EN SHALL select saturating add/sub.
REQ-030 With SEQ_CU_SAT_EN defined, add/sub with overflow=1 SHALL clamp res_l to max positive (0111..1) if operand A is non-negative, otherwise to min negative (100..0); overflow is still reported and cout is unchanged.
REQ-031 Without SEQ_CU_SAT_EN, add/sub SHALL wrap modulo 2^WIDTH.

Verification (WIDTH=8)
REQ-032 Add 0x7F+0x01 -> done at cycle 1; res_l=0x80, res_h=0x00, overflow=1, cout=0, zero=0; with SEQ_CU_SAT_EN, res_l=0x7F.
REQ-033 Sub 0x05-0x05 -> res_l=0x00, res_h=0xFF, zero=1, cout=1, overflow=0.
REQ-034 Mul 0xFD*0x05 (-3*5) -> busy for 9 cycles, done at cycle 9; res_h=0xFF, res_l=0xF1, overflow=0, zero=0.
REQ-035 Mul 0x80*0x80 -> res_h=0x40, res_l=0x00, overflow=1; a start pulsed with new operands during MUL is ignored and produces no extra done.
REQ-036 Assert rst at cycle 4 of a mul -> next cycle is IDLE with all outputs 0 and no done; a following add 0x03&... opcode 11 with a=0xF0, b=0x3C -> res_l=0x30, res_h=0x00.

Source files
------------

// File: rtl/seq_control_unit.sv
// Sequential control unit: single-cycle add/sub/and, iterative signed multiply over WIDTH cycles.
// Optional macro SEQ_CU_SAT_EN selects saturating add/sub (default build wraps modulo 2^WIDTH).
module seq_control_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_l,
  output logic [WIDTH-1:0] res_h,
  output logic             zero,
  output logic             overflow,
  output logic             cout
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [1:0]      OP_MUL = 2'b10;
  localparam logic [1:0]      OP_AND = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res_l_q, res_l_d, res_h_q, res_h_d;
  logic               zero_q, zero_d, overflow_q, overflow_d, cout_q, cout_d;

  logic [2*WIDTH-1:0] a_ext, pp, acc_step;
  logic [1:0]         op;
  logic [WIDTH-1:0]   opa, opb, bop;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   r_l, r_h;
  logic               r_zero, r_ovf, r_cout;

  // One multiplier bit per cycle; the MSB of b carries negative weight, so it is subtracted.
  always_comb begin
    a_ext    = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    pp       = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    acc_step = (cnt_q == LAST) ? (acc_q - pp) : (acc_q + pp);
  end

  // Result packing is shared by both completion edges: IDLE->DONE uses the
  // operands being accepted, MUL->DONE uses the latched opcode and product.
  always_comb begin
    op  = (state_q == S_IDLE) ? ctrl : ctrl_q;
    opa = (state_q == S_IDLE) ? a    : a_q;
    opb = (state_q == S_IDLE) ? b    : b_q;
    bop = op[0] ? ~opb : opb;
    sum = {1'b0, opa} + {1'b0, bop} + {{WIDTH{1'b0}}, op[0]};
    r_l    = '0;
    r_h    = '0;
    r_ovf  = 1'b0;
    r_cout = 1'b0;
    case (op)
      OP_MUL: begin
        r_l   = acc_step[WIDTH-1:0];
        r_h   = acc_step[2*WIDTH-1:WIDTH];
        r_ovf = (r_h != {WIDTH{r_l[WIDTH-1]}});
      end
      OP_AND: r_l = opa & opb;
      default: begin
        r_l    = sum[WIDTH-1:0];
        r_cout = sum[WIDTH];
        r_h    = {WIDTH{sum[WIDTH]}};
        r_ovf  = (opa[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
`ifdef SEQ_CU_SAT_EN
        if (r_ovf) begin
          r_l = opa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    endcase
    r_zero = (op == OP_MUL) ? ({r_h, r_l} == '0) : (r_l == '0);
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    res_l_d    = res_l_q;
    res_h_d    = res_h_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    cout_d     = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          ctrl_d = ctrl;
          if (ctrl == OP_MUL) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            state_d    = S_DONE;
            res_l_d    = r_l;
            res_h_d    = r_h;
            zero_d     = r_zero;
            overflow_d = r_ovf;
            cout_d     = r_cout;
          end
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d    = S_DONE;
          cnt_d      = '0;
          res_l_d    = r_l;
          res_h_d    = r_h;
          zero_d     = r_zero;
          overflow_d = r_ovf;
          cout_d     = r_cout;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      res_l_q    <= '0;
      res_h_q    <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      cout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      res_l_q    <= res_l_d;
      res_h_q    <= res_h_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      cout_q     <= cout_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign res_l    = res_l_q;
  assign res_h    = res_h_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
  assign cout     = cout_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit (WIDTH=8): directed table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_seq_control_unit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   ctrl;
  logic [W-1:0] a, b;
  logic         busy, done, zero, overflow, cout;
  logic [W-1:0] res_l, res_h;

  seq_control_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .busy(busy), .done(done), .res_l(res_l), .res_h(res_h),
    .zero(zero), .overflow(overflow), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rl;
    logic [7:0] rh;
    logic       z;
    logic       ov;
    logic       co;
  } res_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
    res_t       e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    res_t r;
    int sx, sy, s, ux, uy, p;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    r  = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    case (op)
      2'd0, 2'd1: begin
        if (op == 2'd0) begin
          s    = sx + sy;
          r.co = (ux + uy) > 255;
          r.rl = 8'(ux + uy);
        end else begin
          s    = sx - sy;
          r.co = (ux >= uy);
          r.rl = 8'(ux - uy);
        end
        r.ov = (s > 127) || (s < -128);
        r.rh = r.co ? 8'hFF : 8'h00;
`ifdef SEQ_CU_SAT_EN
        if (r.ov) r.rl = (s > 0) ? 8'h7F : 8'h80;
`endif
        r.z = (r.rl == 8'h00);
      end
      2'd2: begin
        p = sx * sy;
        {r.rh, r.rl} = 16'(p);
        r.ov = (p > 127) || (p < -128);
        r.z  = (p == 0);
      end
      default: begin
        r.rl = x & y;
        r.z  = (r.rl == 8'h00);
      end
    endcase
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t e);
    check({tag, " res_l"}, res_l, e.rl);
    check({tag, " res_h"}, res_h, e.rh);
    check({tag, " zero"}, zero, e.z);
    check({tag, " overflow"}, overflow, e.ov);
    check({tag, " cout"}, cout, e.co);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check_res(tag, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
  endtask

  // Issue one operation, wait (bounded) for done, check latency, results and return to idle.
  task automatic run_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        input res_t e, input bit noise, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; ctrl = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    seen  = 1'b0;
    while (lat <= 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({tag, " busy_mul"}, busy, 1);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        ctrl  = 2'($urandom);
        a     = 8'($urandom);
        b     = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, (op == 2'd2) ? W + 1 : 1);
    if (seen) begin
      check({tag, " busy_done"}, busy, 1);
      check_res(tag, e);
    end
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " idle"}, busy, 0);
    @(negedge clk);
    check({tag, " hold_l"}, res_l, e.rl);
    check({tag, " hold_h"}, res_h, e.rh);
  endtask

`ifdef SEQ_CU_SAT_EN
  localparam logic [7:0] ADD_OVF_L = 8'h7F;
  localparam logic [7:0] SUB_OVF_L = 8'h80;
`else
  localparam logic [7:0] ADD_OVF_L = 8'h80;
  localparam logic [7:0] SUB_OVF_L = 8'h7F;
`endif

  vec_t tbl[12];

  initial begin
    int dcnt, dcyc;
    logic [7:0] snap_l, snap_h;
    logic       snap_ov;
    logic [1:0] rop;
    logic [7:0] rx, ry;
    logic [7:0] corners[5];

    tbl[0]  = '{2'd0, 8'h7F, 8'h01, '{ADD_OVF_L, 8'h00, 1'b0, 1'b1, 1'b0}};
    tbl[1]  = '{2'd1, 8'h05, 8'h05, '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1}};
    tbl[2]  = '{2'd2, 8'hFD, 8'h05, '{8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{2'd2, 8'h80, 8'h80, '{8'h00, 8'h40, 1'b0, 1'b1, 1'b0}};
    tbl[4]  = '{2'd3, 8'hF0, 8'h3C, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0}};
    tbl[5]  = '{2'd1, 8'h00, 8'h01, '{8'hFF, 8'h00, 1'b0, 1'b0, 1'b0}};
    tbl[6]  = '{2'd0, 8'hFF, 8'h01, '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b1}};
    tbl[7]  = '{2'd1, 8'h80, 8'h01, '{SUB_OVF_L, 8'hFF, 1'b0, 1'b1, 1'b1}};
    tbl[8]  = '{2'd2, 8'h00, 8'h7F, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0}};
    tbl[9]  = '{2'd2, 8'h7F, 8'h7F, '{8'h01, 8'h3F, 1'b0, 1'b1, 1'b0}};
    tbl[10] = '{2'd3, 8'h55, 8'hAA, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0}};
    tbl[11] = '{2'd2, 8'hFF, 8'hFF, '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0}};
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    rst = 1'b1; start = 1'b0; ctrl = 2'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    check_cleared("post_reset_idle");

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].e, 1'b0, $sformatf("vec%0d", i));
    end

    // Start with new operands held through early MUL cycles must be ignored.
    @(negedge clk);
    start = 1'b1; ctrl = 2'd2; a = 8'h80; b = 8'h80;
    @(negedge clk);
    ctrl = 2'd0; a = 8'h01; b = 8'h01;
    dcnt = 0; dcyc = 0; snap_l = '0; snap_h = '0; snap_ov = 1'b0;
    for (int i = 2; i <= 17; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        dcyc    = i;
        snap_l  = res_l;
        snap_h  = res_h;
        snap_ov = overflow;
      end
      if (i == 5) start = 1'b0;
    end
    check("mulign done_count", dcnt, 1);
    check("mulign done_cycle", dcyc, 9);
    check("mulign res_l", snap_l, 8'h00);
    check("mulign res_h", snap_h, 8'h40);
    check("mulign overflow", snap_ov, 1'b1);

    // Reset during a multiply: clears everything, no done afterwards.
    @(negedge clk);
    start = 1'b1; ctrl = 2'd2; a = 8'hFD; b = 8'h05;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midmul_reset");
    rst  = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midmul no_done", dcnt, 0);
    run_op(2'd3, 8'hF0, 8'h3C, '{8'h30, 8'h00, 1'b0, 1'b0, 1'b0}, 1'b0, "after_reset_and");

    // A start presented during the DONE cycle must be ignored.
    @(negedge clk);
    start = 1'b1; ctrl = 2'd0; a = 8'h02; b = 8'h03;
    @(negedge clk);
    check("donestart done", done, 1);
    check("donestart res", res_l, 8'h05);
    ctrl = 2'd1; a = 8'h09; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    check("donestart busy", busy, 0);
    check("donestart done2", done, 0);
    @(negedge clk);
    check("donestart not_accepted", busy, 0);
    check("donestart res_hold", res_l, 8'h05);

    for (int n = 0; n < 150; n++) begin
      rop = 2'($urandom);
      rx  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom);
      ry  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 8'($urandom);
      run_op(rop, rx, ry, model(rop, rx, ry), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d op%0d %02h,%02h", n, rop, rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
